sha_msg_sched: RTL and testbench

Sequential SHA-256 message-schedule generator feeding the core's hashing datapath. It accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready input stream. It then produces the 64 schedule words W[0..63] in order on a valid/ready output stream. The core consumes these words alongside its sigma/rotate ALU operations. The block is the producer side of the schedule words that the datapath reads.

---
 rtl/sha_msg_sched.sv | 110 +++++++++++
 tb/tb_sha_msg_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule generator: loads one 16-word block, then streams W[0..63].
// A 16-word sliding window holds W[t..t+15]; each output handshake appends W[t+16].
module sha_msg_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic [5:0]  out_idx_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [3:0]  lcnt_q, lcnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_next;

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window slot 0 is W[t]; slots 1, 9 and 14 are W[t+1], W[t+9], W[t+14].
  assign w_next = ss1(win_q[14]) + win_q[9] + ss0(win_q[1]) + win_q[0];

  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    t_d         = t_q;
    win_d       = win_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    out_data_o  = '0;
    out_idx_o   = t_q;

    case (state_q)
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          for (int unsigned i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = in_data_i;
          if (lcnt_q == 4'd15) begin
            lcnt_d  = '0;
            t_d     = '0;
            state_d = EMIT;
          end else begin
            lcnt_d = lcnt_q + 4'd1;
          end
        end
      end

      EMIT: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
        out_data_o  = win_q[0];
        if (out_ready_i) begin
          for (int unsigned i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_next;
          if (t_q == 6'd63) begin
            t_d     = '0;
            state_d = LOAD;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      lcnt_q  <= '0;
      t_q     <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      t_q     <= t_d;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: "abc" block, backpressure, input gaps,
// reset mid-emit, reset mid-load and back-to-back blocks.
module tb_sha_msg_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_ready = 1'b0;
  logic        busy;

  sha_msg_sched dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] cur_blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap [64];

  typedef struct {
    int          idx;
    logic [31:0] w;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule using the textbook recurrence over a flat array.
  task automatic build_sched();
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = cur_blk[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
    build_sched();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_busy"},      {31'b0, busy},      32'd0);
    chk({tag, "_out_data"},  out_data,           32'd0);
    chk({tag, "_out_idx"},   {26'b0, out_idx},   32'd0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_block(input bit gaps);
    int guard;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = cur_blk[k];
      guard = 0;
      while (!in_ready && guard < 200) begin
        tick();
        guard++;
      end
      if (!in_ready) chk("load_ready_timeout", 32'd0, 32'd1);
      chk("load_out_valid_low", {31'b0, out_valid}, 32'd0);
      tick();
      if (gaps && k < 15) begin
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        chk("gap_out_valid_low", {31'b0, out_valid}, 32'd0);
        tick();
      end
    end
    in_valid = 1'b0;
    chk("w0_latency_valid", {31'b0, out_valid}, 32'd1);
    chk("w0_latency_idx", {26'b0, out_idx}, 32'd0);
  endtask

  // Takes words until 64 are consumed, or stops with word stop_at presented.
  task automatic run_emit(input int stall_at, input int stop_at);
    int i = 0;
    int guard = 0;
    out_ready = 1'b1;
    while (i < 64 && guard < 400) begin
      if (out_valid) begin
        if (i == stop_at) break;
        chk($sformatf("idx_%0d", i), {26'b0, out_idx}, i);
        chk($sformatf("w_%0d", i), out_data, exp_w[i]);
        if (i == 0) begin
          chk("emit_in_ready_low", {31'b0, in_ready}, 32'd0);
          chk("emit_busy", {31'b0, busy}, 32'd1);
        end
        cap[i] = out_data;
        if (i == stall_at) begin
          out_ready = 1'b0;
          repeat (5) begin
            tick();
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", out_data, exp_w[i]);
            chk("stall_idx", {26'b0, out_idx}, i);
          end
          out_ready = 1'b1;
        end
        tick();
        i++;
      end else begin
        tick();
      end
      guard++;
    end
    if (stop_at < 0) begin
      chk("emit_word_count", i, 64);
      chk("post_emit_in_ready", {31'b0, in_ready}, 32'd1);
      chk("post_emit_out_valid", {31'b0, out_valid}, 32'd0);
    end else begin
      chk("stop_point_reached", i, stop_at);
    end
    out_ready = 1'b0;
  endtask

  task automatic table_check(input string tag);
    for (int v = 0; v < 7; v++) begin
      chk($sformatf("%s_tbl_w%0d", tag, tbl[v].idx), cap[tbl[v].idx], tbl[v].w);
    end
  endtask

  initial begin
    int k, n, cyc;
    bit hs_in, hs_out;

    tbl[0] = '{0,  32'h61626380};
    tbl[1] = '{1,  32'h00000000};
    tbl[2] = '{14, 32'h00000000};
    tbl[3] = '{15, 32'h00000018};
    tbl[4] = '{16, 32'h61626380};
    tbl[5] = '{17, 32'h000F0000};
    tbl[6] = '{18, 32'h7DA86405};

    #1;
    pulse_reset();
    chk_reset_outs("por");

    // "abc" block with a 5-cycle stall while W[17] is presented
    set_abc();
    load_block(1'b0);
    run_emit(17, -1);
    table_check("abc");

    // Same block with in_valid toggling every cycle
    for (int i = 0; i < 64; i++) cap[i] = 32'hX;
    load_block(1'b1);
    run_emit(-1, -1);
    table_check("gaps");

    // Reset with W[30] presented, then an all-zero block
    load_block(1'b0);
    run_emit(-1, 30);
    pulse_reset();
    chk_reset_outs("rst_emit");
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    build_sched();
    load_block(1'b0);
    run_emit(-1, -1);

    // Reset after 7 input words, then two back-to-back "abc" blocks
    set_abc();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 32'hA5A50000 + i;
      tick();
    end
    pulse_reset();
    chk_reset_outs("rst_load");

    in_valid = 1'b1;
    out_ready = 1'b1;
    k = 0;
    n = 0;
    cyc = 0;
    while (n < 128 && cyc < 400) begin
      in_data = cur_blk[k % 16];
      if (out_valid) begin
        chk($sformatf("b2b_idx_%0d", n), {26'b0, out_idx}, n % 64);
        chk($sformatf("b2b_w_%0d", n), out_data, exp_w[n % 64]);
        if (in_ready) chk("b2b_ready_excl", {31'b0, in_ready}, 32'd0);
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid;
      tick();
      cyc++;
      if (hs_in) k++;
      if (hs_out) n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_words", n, 128);
    chk("b2b_cycles", cyc, 160);
    chk("b2b_in_words", k, 32);
    chk("b2b_end_in_ready", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
